// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps an 8:1 mux select through channels 0..7 and
// packs the sampled bits into a byte; MUX_SCAN_PARITY_EN adds parity.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       parity
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] ch_q, ch_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] asm_q, asm_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic [7:0] byte_w;

  // Completed byte including the bit sampled on the final edge
  assign byte_w = {mux_out, asm_q[6:0]};

  // Next-state logic for the scan sequencer
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        ch_d = 3'd0;
        if (start) begin
          state_d = SCAN;
          cnt_d   = 4'd0;
        end
      end
      SCAN: begin
        if (cnt_q == LAST) begin
          cnt_d        = 4'd0;
          asm_d[ch_q]  = mux_out;
          if (ch_q == 3'd7) begin
            data_d  = byte_w;
            valid_d = 1'b1;
            ch_d    = 3'd0;
            state_d = HOLD;
          end else begin
            ch_d = ch_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (data_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ch_d    = 3'd0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any scan in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= 3'd0;
      cnt_q   <= 4'd0;
      asm_q   <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic par_q, par_d;

  // Parity follows the byte load so both change on the same edge
  always_comb begin
    par_d = par_q;
    if (state_q == SCAN && cnt_q == LAST && ch_q == 3'd7) begin
      par_d = ^byte_w;
    end
  end

  // Parity register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign parity = par_q;
`else
  assign parity = 1'b0;
`endif

  assign {s2, s1, s0} = ch_q;
  assign busy         = (state_q != IDLE);
  assign data_out     = data_q;
  assign data_valid   = valid_q;

endmodule
